// File: rtl/axi_dma_rd_mc.sv
// Multi-channel AXI4 read DMA: round-robin descriptor grant, INCR bursts split at 4 KB and max length, AXIS out tagged by channel.
// Latency: AR one cycle after acceptance, data one register stage. Backpressure: rready = tready | ~tvalid. Macro AXI_DMA_RD_MC_ERR_EN enables rresp error status.
module axi_dma_rd_mc #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ADDR_WIDTH    = 16,
    parameter int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH      = 8,
    parameter int AXI_MAX_BURST_LEN = 16,
    parameter int CHANNELS          = 4,
    parameter int CH_WIDTH          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LEN_WIDTH         = 20,
    parameter int TAG_WIDTH         = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*AXI_ADDR_WIDTH-1:0] s_axis_read_desc_addr,
    input  logic [CHANNELS*LEN_WIDTH-1:0]  s_axis_read_desc_len,
    input  logic [CHANNELS*TAG_WIDTH-1:0]  s_axis_read_desc_tag,
    input  logic [CHANNELS-1:0]            s_axis_read_desc_valid,
    output logic [CHANNELS-1:0]            s_axis_read_desc_ready,
    output logic [TAG_WIDTH-1:0]           m_axis_read_desc_status_tag,
    output logic [CH_WIDTH-1:0]            m_axis_read_desc_status_chan,
    output logic                           m_axis_read_desc_status_error,
    output logic                           m_axis_read_desc_status_valid,
    output logic [AXI_DATA_WIDTH-1:0]      m_axis_read_data_tdata,
    output logic [AXI_STRB_WIDTH-1:0]      m_axis_read_data_tkeep,
    output logic                           m_axis_read_data_tvalid,
    input  logic                           m_axis_read_data_tready,
    output logic                           m_axis_read_data_tlast,
    output logic [CH_WIDTH-1:0]            m_axis_read_data_tdest,
    output logic [AXI_ID_WIDTH-1:0]        m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arlock,
    output logic [3:0]                     m_axi_arcache,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]        m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    input  logic                           enable
);

    localparam int SZ = $clog2(AXI_STRB_WIDTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, STATUS} state_t;

    state_t                    state, state_nxt;
    logic                      armed;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      len_q, ar_left, rx_left;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic [CH_WIDTH-1:0]       chan_q, rr_q, grant;
    logic                      grant_vld, accept;
    logic [CH_WIDTH:0]         rr_sum;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]      sel_len, init_beats, rem;
    logic [TAG_WIDTH-1:0]      sel_tag;
    logic [LEN_WIDTH:0]        len_sum;
    logic [12:0]               bnd_beats;
    logic [31:0]               burst_beats;
    logic [AXI_STRB_WIDTH-1:0] last_keep;
    logic                      ar_hs, r_hs, t_hs;
    logic                      unused_in;

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_sum    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rr_sum = {1'b0, rr_q} + (CH_WIDTH+1)'(i);
            if (rr_sum >= (CH_WIDTH+1)'(CHANNELS))
                rr_sum = rr_sum - (CH_WIDTH+1)'(CHANNELS);
            if (!grant_vld && s_axis_read_desc_valid[rr_sum[CH_WIDTH-1:0]]) begin
                grant_vld = 1'b1;
                grant     = rr_sum[CH_WIDTH-1:0];
            end
        end
    end

    assign accept   = armed && enable && grant_vld && (state == IDLE || state == STATUS);
    assign s_axis_read_desc_ready = accept ? (CHANNELS'(1) << grant) : '0;

    assign sel_addr   = s_axis_read_desc_addr[grant*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign sel_len    = s_axis_read_desc_len[grant*LEN_WIDTH +: LEN_WIDTH];
    assign sel_tag    = s_axis_read_desc_tag[grant*TAG_WIDTH +: TAG_WIDTH];
    assign len_sum    = {1'b0, sel_len} + (LEN_WIDTH+1)'(AXI_STRB_WIDTH-1);
    assign init_beats = LEN_WIDTH'(len_sum >> SZ);

    // Burst size: whichever of remaining beats, max length or distance to the 4 KB page end is smallest.
    always_comb begin
        bnd_beats   = 13'((13'd4096 - {1'b0, addr_q[11:0]}) >> SZ);
        burst_beats = 32'(ar_left);
        if (burst_beats > 32'(AXI_MAX_BURST_LEN))
            burst_beats = 32'(AXI_MAX_BURST_LEN);
        if (burst_beats > 32'(bnd_beats))
            burst_beats = 32'(bnd_beats);
    end

    assign m_axi_arid    = AXI_ID_WIDTH'(chan_q);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(burst_beats - 32'd1);
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arvalid = (state == ADDR);
    assign m_axi_rready  = (state == ADDR || state == DATA) &&
                           (m_axis_read_data_tready || !m_axis_read_data_tvalid);

    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;
    assign t_hs  = m_axis_read_data_tvalid && m_axis_read_data_tready;

    assign rem       = len_q & LEN_WIDTH'(AXI_STRB_WIDTH-1);
    assign last_keep = (rem == '0) ? '1 : ~({AXI_STRB_WIDTH{1'b1}} << rem);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, STATUS: begin
                if (accept)
                    state_nxt = (sel_len == '0) ? STATUS : ADDR;
                else
                    state_nxt = IDLE;
            end
            ADDR:    if (ar_hs && 32'(ar_left) == burst_beats) state_nxt = DATA;
            DATA:    if (t_hs && m_axis_read_data_tlast) state_nxt = STATUS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            armed   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            chan_q  <= '0;
            rr_q    <= '0;
            ar_left <= '0;
            rx_left <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                tag_q   <= sel_tag;
                chan_q  <= grant;
                ar_left <= init_beats;
                rx_left <= init_beats;
                rr_q    <= (grant == CH_WIDTH'(CHANNELS-1)) ? '0 : grant + 1'b1;
            end else begin
                if (ar_hs) begin
                    addr_q  <= addr_q + AXI_ADDR_WIDTH'(burst_beats << SZ);
                    ar_left <= ar_left - LEN_WIDTH'(burst_beats);
                end
                if (r_hs)
                    rx_left <= rx_left - 1'b1;
            end
        end
    end

    // Single output register stage; rready only opens when this stage can take the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_read_data_tvalid <= 1'b0;
            m_axis_read_data_tdata  <= '0;
            m_axis_read_data_tkeep  <= '0;
            m_axis_read_data_tlast  <= 1'b0;
            m_axis_read_data_tdest  <= '0;
        end else if (r_hs) begin
            m_axis_read_data_tvalid <= 1'b1;
            m_axis_read_data_tdata  <= m_axi_rdata;
            m_axis_read_data_tdest  <= chan_q;
            m_axis_read_data_tlast  <= (rx_left == LEN_WIDTH'(1));
            m_axis_read_data_tkeep  <= (rx_left == LEN_WIDTH'(1)) ? last_keep : '1;
        end else if (m_axis_read_data_tready) begin
            m_axis_read_data_tvalid <= 1'b0;
            m_axis_read_data_tlast  <= 1'b0;
        end
    end

    assign m_axis_read_desc_status_valid = (state == STATUS);
    assign m_axis_read_desc_status_tag   = tag_q;
    assign m_axis_read_desc_status_chan  = chan_q;

`ifdef AXI_DMA_RD_MC_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (r_hs && m_axi_rresp != 2'b00)
            err_q <= 1'b1;
    end

    assign m_axis_read_desc_status_error = err_q;
`else
    assign m_axis_read_desc_status_error = 1'b0;
`endif

    // Burst accounting is count based, so rid/rlast carry no extra information here.
    assign unused_in = ^{m_axi_rid, m_axi_rlast, m_axi_rresp};

endmodule

// File: tb/tb_axi_dma_rd_mc.sv
// Randomized bench for axi_dma_rd_mc: AXI slave model, AXIS sink and a descriptor-level reference model.
`timescale 1ns/1ps
module tb_axi_dma_rd_mc;
    localparam int DW = 32, AW = 16, SW = 4, IW = 8, CH = 4, CW = 2, LW = 20, TW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CH*AW-1:0] d_addr;
    logic [CH*LW-1:0] d_len;
    logic [CH*TW-1:0] d_tag;
    logic [CH-1:0]    d_valid, d_ready;
    logic [TW-1:0]    st_tag;
    logic [CW-1:0]    st_chan;
    logic             st_err, st_valid;
    logic [DW-1:0]    tdata;
    logic [SW-1:0]    tkeep;
    logic             tvalid, tready, tlast;
    logic [CW-1:0]    tdest;
    logic [IW-1:0]    arid;
    logic [AW-1:0]    araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arlock;
    logic [3:0]       arcache;
    logic [2:0]       arprot;
    logic             arvalid, arready;
    logic [IW-1:0]    rid;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rlast, rvalid, rready, enable;

    axi_dma_rd_mc #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_STRB_WIDTH(SW), .AXI_ID_WIDTH(IW),
        .AXI_MAX_BURST_LEN(16), .CHANNELS(CH), .CH_WIDTH(CW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_read_desc_addr(d_addr), .s_axis_read_desc_len(d_len), .s_axis_read_desc_tag(d_tag),
        .s_axis_read_desc_valid(d_valid), .s_axis_read_desc_ready(d_ready),
        .m_axis_read_desc_status_tag(st_tag), .m_axis_read_desc_status_chan(st_chan),
        .m_axis_read_desc_status_error(st_err), .m_axis_read_desc_status_valid(st_valid),
        .m_axis_read_data_tdata(tdata), .m_axis_read_data_tkeep(tkeep), .m_axis_read_data_tvalid(tvalid),
        .m_axis_read_data_tready(tready), .m_axis_read_data_tlast(tlast), .m_axis_read_data_tdest(tdest),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .enable(enable)
    );

    typedef struct packed {logic [15:0] addr; logic [7:0] len; logic [7:0] id;} ar_t;
    typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last; logic [1:0] dest;} bt_t;
    typedef struct packed {logic [7:0] tag; logic [1:0] chan; logic err;} st_t;
    typedef struct packed {logic [15:0] addr; logic [8:0] beats; logic [7:0] id;} sb_t;

    ar_t exp_ar[$];
    bt_t exp_bt[$];
    st_t exp_st[$];
    sb_t sb_q[$];
    int  grant_log[$];

    logic [3:0]  pend_v = '0;
    logic [15:0] p_addr[CH];
    logic [19:0] p_len[CH];
    logic [7:0]  p_tag[CH];
    int          p_err[CH];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, done_cyc = -10, rr = 0, rnd = 0;
    int sb_idx = 0, r_cnt = 0, cur_err = -1;
    int ar_cnt = 0, beat_cnt = 0, acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    task automatic drive_desc();
        d_valid = pend_v;
        for (int i = 0; i < CH; i++) begin
            d_addr[i*AW +: AW] = p_addr[i];
            d_len[i*LW +: LW]  = p_len[i];
            d_tag[i*TW +: TW]  = p_tag[i];
        end
    endtask

    task automatic post(input int ch, input logic [15:0] a, input logic [19:0] l,
                        input logic [7:0] t, input int e);
        p_addr[ch] = a; p_len[ch] = l; p_tag[ch] = t; p_err[ch] = e;
        pend_v[ch] = 1'b1;
        drive_desc();
    endtask

    // Reference: expected grant, AR split, beat stream and status for one accepted descriptor.
    task automatic accept(input int ch);
        int j, nb, a, left, n, L;
        ar_t r; bt_t b; st_t s;
        j = -1;
        for (int k = 0; k < CH; k++)
            if (j < 0 && pend_v[(rr + k) % CH]) j = (rr + k) % CH;
        chk("grant", ch, j);
        grant_log.push_back(ch);
        rr = (ch + 1) % CH;
        L = int'(p_len[ch]);
        nb = (L + SW - 1) / SW;
        a = int'(p_addr[ch]);
        left = nb;
        while (left > 0) begin
            n = left;
            if (n > 16) n = 16;
            if (n > (4096 - a % 4096) / SW) n = (4096 - a % 4096) / SW;
            r.addr = 16'(a); r.len = 8'(n - 1); r.id = 8'(ch);
            exp_ar.push_back(r);
            a += n * SW;
            left -= n;
        end
        for (int k = 0; k < nb; k++) begin
            b.data = mem(16'(int'(p_addr[ch]) + 4 * k));
            b.last = (k == nb - 1);
            b.keep = (b.last && (L % SW) != 0) ? 4'((1 << (L % SW)) - 1) : 4'hF;
            b.dest = 2'(ch);
            exp_bt.push_back(b);
        end
        s.tag = p_tag[ch];
        s.chan = 2'(ch);
`ifdef AXI_DMA_RD_MC_ERR_EN
        s.err = (p_err[ch] >= 0 && p_err[ch] < nb);
`else
        s.err = 1'b0;
`endif
        exp_st.push_back(s);
        cur_err = p_err[ch];
        r_cnt = 0;
        if (nb == 0) done_cyc = cyc;
        pend_v[ch] = 1'b0;
        acc_cnt++;
    endtask

    task automatic on_ar();
        ar_t e; sb_t s;
        if (exp_ar.size() == 0) begin
            chk("ar_unexpected", 1, 0);
        end else begin
            e = exp_ar.pop_front();
            chk("araddr", araddr, e.addr);
            chk("arlen", arlen, e.len);
            chk("arid", arid, e.id);
            chk("ar_static", {arsize, arburst, arlock, arcache, arprot},
                {3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
        end
        s.addr = araddr; s.beats = 9'(arlen) + 9'd1; s.id = arid;
        sb_q.push_back(s);
        ar_cnt++;
    endtask

    task automatic on_t();
        bt_t e;
        if (exp_bt.size() == 0) begin
            chk("beat_unexpected", 1, 0);
        end else begin
            e = exp_bt.pop_front();
            chk("tdata", tdata, e.data);
            chk("tkeep", tkeep, e.keep);
            chk("tlast", tlast, e.last);
            chk("tdest", tdest, e.dest);
            if (e.last) done_cyc = cyc;
        end
        beat_cnt++;
    endtask

    task automatic on_st();
        st_t e;
        if (exp_st.size() == 0) begin
            chk("status_unexpected", 1, 0);
        end else begin
            e = exp_st.pop_front();
            chk("st_tag", st_tag, e.tag);
            chk("st_chan", st_chan, e.chan);
            chk("st_err", st_err, e.err);
            chk("st_time", cyc, done_cyc + 1);
        end
    endtask

    task automatic drive(input logic r_hs);
        drive_desc();
        arready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        tready  = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(rvalid && !r_hs)) begin
            if (sb_q.size() > 0 && (rnd == 0 || $urandom_range(0, 1) == 1)) begin
                rvalid = 1'b1;
                rdata  = mem(16'(int'(sb_q[0].addr) + 4 * sb_idx));
                rlast  = (sb_idx == int'(sb_q[0].beats) - 1);
                rid    = sb_q[0].id;
                rresp  = (r_cnt == cur_err) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    endtask

    // One clock: observe at the falling edge, drive new inputs just after the rising edge.
    task automatic step();
        logic ar_hs, r_hs, t_hs;
        @(negedge clk);
        cyc++;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        t_hs  = tvalid && tready;
        if (st_valid) on_st();
        if (t_hs) on_t();
        if (r_hs) begin
            if (sb_q.size() == 0) begin
                chk("r_unexpected", 1, 0);
            end else begin
                sb_idx++;
                r_cnt++;
                if (sb_idx == int'(sb_q[0].beats)) begin
                    void'(sb_q.pop_front());
                    sb_idx = 0;
                end
            end
        end
        if (ar_hs) on_ar();
        if (d_ready != '0) begin
            chk("ready_onehot", $countones(d_ready), 1);
            chk("ready_needs_valid", d_ready & ~d_valid, 0);
        end
        for (int i = 0; i < CH; i++)
            if (d_ready[i] && d_valid[i]) accept(i);
        if (tvalid && !tready) chk("rready_stalled", rready, 0);
        @(posedge clk);
        #1;
        drive(r_hs);
    endtask

    task automatic run_done(input int budget);
        int t;
        t = 0;
        while ((pend_v != '0 || exp_ar.size() != 0 || exp_bt.size() != 0 || exp_st.size() != 0)
               && t < budget) begin
            step();
            t++;
        end
        chk("drain_in_budget", (t < budget), 1);
        repeat (3) step();
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_ready"}, d_ready, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_st_valid"}, st_valid, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_araddr"}, araddr, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, b0, c0, ch, t;
        logic [9:0] order;
        for (int i = 0; i < CH; i++) begin
            p_addr[i] = '0; p_len[i] = '0; p_tag[i] = '0; p_err[i] = -1;
        end
        drive_desc();
        enable = 1'b0; arready = 1'b0; tready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        d_valid = 4'hF;
        repeat (3) @(negedge clk);
        reset_outputs_zero("reset");
        d_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;

        post(0, 16'h0000, 20'd64, 8'h11, -1);
        run_done(2000);
        chk("t1_ar_count", ar_cnt, 1);
        chk("t1_beat_count", beat_cnt, 16);

        a0 = ar_cnt; b0 = beat_cnt;
        post(2, 16'h0FF0, 20'd40, 8'h22, -1);
        run_done(2000);
        chk("t2_ar_count", ar_cnt - a0, 2);
        chk("t2_beat_count", beat_cnt - b0, 10);

        a0 = ar_cnt; b0 = beat_cnt;
        post(1, 16'h0100, 20'd7, 8'h33, -1);
        run_done(2000);
        post(1, 16'h0200, 20'd0, 8'h34, -1);
        run_done(2000);
        chk("t3_ar_count", ar_cnt - a0, 1);
        chk("t3_beat_count", beat_cnt - b0, 2);

        post(3, 16'h0300, 20'd4, 8'h40, -1);
        run_done(2000);
        grant_log.delete();
        for (int i = 0; i < CH; i++)
            post(i, 16'(16'h0400 + i * 16'h0100), 20'(16 + 4 * i), 8'(8'h50 + i), -1);
        t = 0;
        while (pend_v[0] && t < 200) begin step(); t++; end
        post(0, 16'h0900, 20'd8, 8'h58, -1);
        run_done(4000);
        chk("rr_grant_count", grant_log.size(), 5);
        order = '0;
        for (int i = 0; i < grant_log.size() && i < 5; i++)
            order = {order[7:0], 2'(grant_log[i])};
        chk("rr_grant_order", order, 10'h06C);

        rnd = 1;
        b0 = beat_cnt;
        post(0, 16'h2000, 20'd256, 8'h60, -1);
        run_done(5000);
        chk("t5_beat_count", beat_cnt - b0, 64);
        rnd = 0;

        post(1, 16'h3000, 20'd32, 8'h70, 3);
        run_done(2000);
        post(1, 16'h3100, 20'd32, 8'h71, -1);
        run_done(2000);

        enable = 1'b0;
        c0 = acc_cnt;
        post(2, 16'h3200, 20'd12, 8'h72, -1);
        repeat (20) step();
        chk("enable_blocks", acc_cnt - c0, 0);
        enable = 1'b1;
        t = 0;
        while (pend_v[2] && t < 100) begin step(); t++; end
        enable = 1'b0;
        run_done(2000);
        chk("inflight_completes", acc_cnt - c0, 1);
        enable = 1'b1;

        rnd = 1;
        for (int n = 0; n < 60; n++) begin
            ch = $urandom_range(0, CH - 1);
            if (!pend_v[ch])
                post(ch, 16'({$urandom_range(0, 16'h37FF), 2'b00}), 20'($urandom_range(0, 200)),
                     8'(n), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1);
            repeat ($urandom_range(0, 20)) step();
        end
        run_done(40000);
        rnd = 0;

        post(3, 16'h4000, 20'd512, 8'h80, -1);
        repeat (40) step();
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("midreset");
        exp_ar.delete(); exp_bt.delete(); exp_st.delete(); sb_q.delete();
        sb_idx = 0; pend_v = '0; rr = 0;
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
        drive_desc();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        post(3, 16'h5000, 20'd20, 8'h90, -1);
        post(1, 16'h5100, 20'd9, 8'h91, -1);
        run_done(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
